// File: rtl/fft_peak_detect.sv
// AXIS register-slice pass-through on the FFT output stream that also squares
// every bin, tracks the per-frame peak and keeps framing statistics.
module fft_peak_detect #(
  parameter int NFFT   = 8,
  parameter int DATA_W = 32,
  parameter int MAG_W  = 2*DATA_W+1,
  localparam int BIN_W = $clog2(NFFT)
) (
  input  logic                clk,
  input  logic                resetn,
  // Stream handshakes: a beat moves on an edge where tvalid && tready; a
  // producer holds tvalid/tdata/tlast stable until that edge.
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic [2*DATA_W-1:0] s_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [2*DATA_W-1:0] m_tdata,
  input  logic                clear,
  output logic [BIN_W-1:0]    peak_bin,
  output logic [MAG_W-1:0]    peak_mag,
  output logic                frame_done,
  output logic [31:0]         frame_count,
  output logic                err_early,
  output logic                err_missing
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NFFT-1);

  logic                m_tvalid_q, m_tvalid_d;
  logic                m_tlast_q, m_tlast_d;
  logic [2*DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic [BIN_W-1:0]    bin_q, bin_d;

  logic                s1_vld_q, s1_vld_d;
  logic                s1_end_q, s1_end_d;
  logic [BIN_W-1:0]    s1_bin_q, s1_bin_d;
  logic [2*DATA_W-1:0] sq_re_q, sq_re_d;
  logic [2*DATA_W-1:0] sq_im_q, sq_im_d;

  logic                run_first_q, run_first_d;
  logic [BIN_W-1:0]    run_bin_q, run_bin_d;
  logic [MAG_W-1:0]    run_mag_q, run_mag_d;

  logic [BIN_W-1:0]    peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0]    peak_mag_q, peak_mag_d;
  logic                frame_done_q, frame_done_d;
  logic [31:0]         frame_count_q, frame_count_d;
  logic                err_early_q, err_early_d;
  logic                err_missing_q, err_missing_d;

  logic                       s_accept;
  logic                       at_last;
  logic                       beat_end;
  logic signed [DATA_W-1:0]   s_re, s_im;
  logic signed [2*DATA_W-1:0] prod_re, prod_im;
  logic [MAG_W-1:0]           sum;
  logic                       take;
  logic [BIN_W-1:0]           win_bin;
  logic [MAG_W-1:0]           win_mag;

  assign s_tready = !m_tvalid_q || m_tready;

  always_comb begin
    s_accept = s_tvalid && s_tready;
    at_last  = (bin_q == LAST_BIN);
    beat_end = s_tlast || at_last;
    s_re     = s_tdata[DATA_W-1:0];
    s_im     = s_tdata[2*DATA_W-1:DATA_W];
    prod_re  = s_re * s_re;
    prod_im  = s_im * s_im;

    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    if (s_accept) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = s_tlast;
      m_tdata_d  = s_tdata;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end

    bin_d = bin_q;
    if (s_accept) bin_d = beat_end ? '0 : bin_q + BIN_W'(1);

    // Squares are taken at the accept point so downstream stalls never
    // disturb the magnitude pipeline.
    s1_vld_d = s_accept;
    s1_end_d = s1_end_q;
    s1_bin_d = s1_bin_q;
    sq_re_d  = sq_re_q;
    sq_im_d  = sq_im_q;
    if (s_accept) begin
      s1_end_d = beat_end;
      s1_bin_d = bin_q;
      sq_re_d  = prod_re;
      sq_im_d  = prod_im;
    end

    sum     = MAG_W'(sq_re_q) + MAG_W'(sq_im_q);
    take    = run_first_q || (sum > run_mag_q);
    win_bin = take ? s1_bin_q : run_bin_q;
    win_mag = take ? sum : run_mag_q;

    run_first_d   = run_first_q;
    run_bin_d     = run_bin_q;
    run_mag_d     = run_mag_q;
    peak_bin_d    = peak_bin_q;
    peak_mag_d    = peak_mag_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_early_d   = err_early_q;
    err_missing_d = err_missing_q;

    if (s1_vld_q) begin
      if (s1_end_q) begin
        peak_bin_d    = win_bin;
        peak_mag_d    = win_mag;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 32'd1;
        run_first_d   = 1'b1;
        run_bin_d     = '0;
        run_mag_d     = '0;
      end else begin
        run_first_d = 1'b0;
        run_bin_d   = win_bin;
        run_mag_d   = win_mag;
      end
    end

    if (s_accept && s_tlast && !at_last) err_early_d = 1'b1;
    if (s_accept && at_last && !s_tlast) err_missing_d = 1'b1;

    // clear wins over a same-edge increment or error set.
    if (clear) begin
      frame_count_d = '0;
      err_early_d   = 1'b0;
      err_missing_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tdata_q     <= '0;
      bin_q         <= '0;
      s1_vld_q      <= 1'b0;
      s1_end_q      <= 1'b0;
      s1_bin_q      <= '0;
      sq_re_q       <= '0;
      sq_im_q       <= '0;
      run_first_q   <= 1'b1;
      run_bin_q     <= '0;
      run_mag_q     <= '0;
      peak_bin_q    <= '0;
      peak_mag_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tdata_q     <= m_tdata_d;
      bin_q         <= bin_d;
      s1_vld_q      <= s1_vld_d;
      s1_end_q      <= s1_end_d;
      s1_bin_q      <= s1_bin_d;
      sq_re_q       <= sq_re_d;
      sq_im_q       <= sq_im_d;
      run_first_q   <= run_first_d;
      run_bin_q     <= run_bin_d;
      run_mag_q     <= run_mag_d;
      peak_bin_q    <= peak_bin_d;
      peak_mag_q    <= peak_mag_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
    end
  end

  assign m_tvalid    = m_tvalid_q;
  assign m_tlast     = m_tlast_q;
  assign m_tdata     = m_tdata_q;
  assign peak_bin    = peak_bin_q;
  assign peak_mag    = peak_mag_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_early   = err_early_q;
  assign err_missing = err_missing_q;

endmodule
